stream_fifo_struct: RTL

- Multi-entry valid/ready FIFO carrying an arbitrary packed struct payload.
- Sits downstream of skid_buffer_struct stages: it is the consuming end that absorbs bursts.
- Used for dispatch/issue queueing in the out-of-order core.
- Adds a synchronous flush for mispredict recovery and exposes an occupancy count.

---
 rtl/core_pkg.sv | 21 ++
 rtl/stream_fifo_struct.sv | 84 ++++++++
 2 files changed

// File: rtl/core_pkg.sv
// Shared pipeline payload types and queue sizing for the out-of-order core.
package core_pkg;

  localparam int unsigned QUEUE_DEPTH = 4;

  localparam int unsigned UOP_TAG_W = 4;
  localparam int unsigned UOP_OP_W  = 4;

  // Compact dispatch micro-op payload carried through issue queues.
  typedef struct packed {
    logic [UOP_TAG_W-1:0] tag;
    logic [UOP_OP_W-1:0]  op;
  } uop_t;

  // Next pointer value, wrapping from depth-1 back to 0.
  function automatic int unsigned wrap_ptr_inc(input int unsigned ptr,
                                               input int unsigned depth);
    return (ptr + 1) % depth;
  endfunction

endpackage

// File: rtl/stream_fifo_struct.sv
// Valid/ready FIFO for packed-struct payloads with synchronous flush and occupancy count.
module stream_fifo_struct
  import core_pkg::*;
#(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = QUEUE_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  T                       data_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output T                       data_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Handshake status decoded purely from registered occupancy.
  always_comb begin
    ready_in  = (count_q != CNT_W'(DEPTH));
    valid_out = (count_q != '0);
    data_out  = mem_q[rd_ptr_q];
    count     = count_q;
    push      = valid_in && ready_in;
    pop       = valid_out && ready_out;
  end

  // Next pointer/count state; flush overrides any concurrent push or pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = PTR_W'(wrap_ptr_inc(32'(wr_ptr_q), DEPTH));
      end
      if (pop) begin
        rd_ptr_d = PTR_W'(wrap_ptr_inc(32'(rd_ptr_q), DEPTH));
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule
